// File: rtl/seq_modulo_if.sv
// Handshake bundle for seq_modulo: start/operands in, status/results out.
// Adds quotient port q when SEQ_MODULO_QUOT_EN is defined.
interface seq_modulo_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             err;
`ifdef SEQ_MODULO_QUOT_EN
  logic [WIDTH-1:0] q;

  modport master (
    output start, a, b,
    input  busy, done, y, err, q
  );
  modport slave (
    input  start, a, b,
    output busy, done, y, err, q
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, y, err
  );
  modport slave (
    input  start, a, b,
    output busy, done, y, err
  );
`endif
endinterface

// File: rtl/seq_modulo.sv
// Sequential restoring-division modulo unit, one bit per cycle.
// Optional quotient output q under SEQ_MODULO_QUOT_EN.
module seq_modulo #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  seq_modulo_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] y_r;
  logic             err_r;

  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   sub;
  logic             take;
  logic             accept;
  logic             zero_b;
  logic             last;

`ifdef SEQ_MODULO_QUOT_EN
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_r;
`endif

  assign accept = (state == IDLE) && bus.start;
  assign zero_b = (bus.b == '0);
  assign last   = (cnt == LAST);

  // Shift next dividend bit into the widened remainder, then try b.
  always_comb begin
    shl  = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
    take = (shl >= {1'b0, dvs});
    sub  = take ? (shl - {1'b0, dvs}) : shl;
  end

`ifdef SEQ_MODULO_QUOT_EN
  assign quo_nx = (quo << 1) | WIDTH'(take);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = zero_b ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      y_r   <= '0;
      err_r <= 1'b0;
`ifdef SEQ_MODULO_QUOT_EN
      quo   <= '0;
      q_r   <= '0;
`endif
    end else if (accept) begin
      dvd <= bus.a;
      dvs <= bus.b;
      rem <= '0;
      cnt <= '0;
`ifdef SEQ_MODULO_QUOT_EN
      quo <= '0;
`endif
      if (zero_b) begin
        y_r   <= bus.a;
        err_r <= 1'b1;
`ifdef SEQ_MODULO_QUOT_EN
        q_r   <= '1;
`endif
      end
    end else if (state == CALC) begin
      dvd <= dvd << 1;
      rem <= sub;
      cnt <= cnt + CW'(1);
`ifdef SEQ_MODULO_QUOT_EN
      quo <= quo_nx;
`endif
      if (last) begin
        y_r   <= sub[WIDTH-1:0];
        err_r <= 1'b0;
`ifdef SEQ_MODULO_QUOT_EN
        q_r   <= quo_nx;
`endif
      end
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE);
  assign bus.y    = y_r;
  assign bus.err  = err_r;
`ifdef SEQ_MODULO_QUOT_EN
  assign bus.q    = q_r;
`endif

endmodule
